// File: rtl/data_access_unit_if.sv
// data_access_unit_if: request/response handshake between the execute stage and the load/store unit.
interface data_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_access_unit.sv
// data_access_unit: RV32 load/store unit; splits word-crossing accesses into two aligned memory cycles.
module data_access_unit #(
    parameter int DATA_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    data_access_unit_if.slave    req,
    output logic [DATA_BITS-3:0] mem_address,
    output logic [3:0]           mem_byteena,
    output logic [31:0]          mem_data,
    output logic                 mem_wren,
    input  logic [31:0]          mem_q
);
    localparam int AW = DATA_BITS - 2;
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_e;
    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic                   err_q, err_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [DATA_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d;
    logic [1:0]             off;
    logic [AW-1:0]          word;
    logic [3:0]             size_mask;
    logic [7:0]             m8;
    logic [63:0]            s64, ld64;
    logic [31:0]            ld;
    logic                   bad;
    logic                   unused_addr;
    assign unused_addr = ^req.req_addr[31:DATA_BITS];
    always_comb begin
        off       = addr_q[1:0];
        word      = addr_q[DATA_BITS-1:2];
        size_mask = funct3_q[1:0] == 2'b00 ? 4'b0001 : funct3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        m8        = {4'b0000, size_mask} << off;
        s64       = {32'b0, wdata_q} << {off, 3'b000};
        ld64      = {hi_q, lo_q} >> {off, 3'b000};
        ld        = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & ld64[7]}}, ld64[7:0]} :
                    funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & ld64[15]}}, ld64[15:0]} : ld64[31:0];
        // size 11 is never legal; stores also reject any funct3 with bit 2 set
        bad       = (req.req_funct3[1:0] == 2'b11) |
                    (req.req_write ? req.req_funct3[2] : req.req_funct3[2:1] == 2'b11);
    end
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        err_d           = err_q;
        funct3_d        = funct3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        req.req_ready   = 1'b0;
        req.resp_valid  = 1'b0;
        req.resp_rdata  = 32'b0;
        req.resp_error  = 1'b0;
        mem_address     = '0;
        mem_byteena     = 4'b0;
        mem_data        = 32'b0;
        mem_wren        = 1'b0;
        case (state_q)
            IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    write_d  = req.req_write;
                    funct3_d = req.req_funct3;
                    addr_d   = req.req_addr[DATA_BITS-1:0];
                    wdata_d  = req.req_wdata;
                    err_d    = bad;
                    state_d  = bad ? DONE : ACC0;
                end
            end
            ACC0: begin
                mem_address = word;
                mem_byteena = m8[3:0];
                mem_data    = s64[31:0];
                mem_wren    = write_q;
                lo_d        = write_q ? lo_q : mem_q;
                state_d     = |m8[7:4] ? ACC1 : DONE;
            end
            ACC1: begin
                mem_address = word + AW'(1);
                mem_byteena = m8[7:4];
                mem_data    = s64[63:32];
                mem_wren    = write_q;
                hi_d        = write_q ? hi_q : mem_q;
                state_d     = DONE;
            end
            default: begin
                req.resp_valid = 1'b1;
                req.resp_error = err_q;
                req.resp_rdata = (write_q | err_q) ? 32'b0 : ld;
                state_d        = IDLE;
            end
        endcase
        if (reset) begin
            {req.req_ready, req.resp_valid, req.resp_error, req.resp_rdata} = '0;
            {mem_address, mem_byteena, mem_data, mem_wren} = '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            lo_q     <= 32'b0;
            hi_q     <= 32'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end
endmodule

// File: tb/tb_data_access_unit.sv
// tb_data_access_unit: directed load/store vectors against a byte-enabled word memory model.
module tb_data_access_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [31:0] mem [0:16383];
    int          n_cmp = 0;
    int          n_err = 0;
    always #5 clock = ~clock;
    data_access_unit_if bus();
    data_access_unit #(.DATA_BITS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (bus),
        .mem_address(mem_address),
        .mem_byteena(mem_byteena),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );
    assign mem_q = mem[mem_address];
    always @(posedge clock)
        if (mem_wren)
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        step();
        bus.req_valid  = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'b0;
        mem[14'h0080] = 32'h4433_2211;
        mem[14'h0081] = 32'h8877_6655;
        mem[14'h3FFF] = 32'hBBAA_0000;
        mem[14'h0000] = 32'h0000_DDCC;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'b0;
        bus.req_wdata  = 32'b0;
        step();
        step();
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_error", {31'b0, bus.resp_error}, 32'd0);
        chk("rst_mem", {mem_address, mem_byteena, mem_wren, 13'b0}, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("sw_wren", {31'b0, mem_wren}, 32'd1);
        chk("sw_byteena", {28'b0, mem_byteena}, 32'hF);
        chk("sw_addr", {18'b0, mem_address}, 32'h40);
        chk("sw_data", mem_data, 32'hDEAD_BEEF);
        chk("busy_ready", {31'b0, bus.req_ready}, 32'd0);
        step();
        chk("sw_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("sw_resp_rdata", bus.resp_rdata, 32'd0);
        step();
        chk("idle_ready", {31'b0, bus.req_ready}, 32'd1);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        chk("lw_wren", {31'b0, mem_wren}, 32'd0);
        chk("lw_addr", {18'b0, mem_address}, 32'h40);
        step();
        chk("lw_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("lw_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
        step();
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080);
        chk("sb_byteena", {28'b0, mem_byteena}, 32'h8);
        chk("sb_data", mem_data, 32'h8000_0000);
        step();
        step();
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        step();
        chk("lb_rdata", bus.resp_rdata, 32'hFFFF_FF80);
        step();
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        step();
        chk("lbu_rdata", bus.resp_rdata, 32'h0000_0080);
        step();
        issue(1'b0, 3'b010, 32'h0000_0203, 32'h0);
        chk("lwx_acc0_addr", {18'b0, mem_address}, 32'h80);
        chk("lwx_acc0_be", {28'b0, mem_byteena}, 32'h8);
        step();
        chk("lwx_acc1_addr", {18'b0, mem_address}, 32'h81);
        chk("lwx_acc1_be", {28'b0, mem_byteena}, 32'h7);
        chk("lwx_acc1_noresp", {31'b0, bus.resp_valid}, 32'd0);
        step();
        chk("lwx_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("lwx_rdata", bus.resp_rdata, 32'h7766_5544);
        step();
        issue(1'b1, 3'b001, 32'h0000_0107, 32'h0000_ABCD);
        chk("shx_acc0_be", {28'b0, mem_byteena}, 32'h8);
        chk("shx_acc0_data", mem_data, 32'hCD00_0000);
        step();
        chk("shx_acc1_be", {28'b0, mem_byteena}, 32'h1);
        chk("shx_acc1_data", mem_data, 32'h0000_00AB);
        chk("shx_acc1_addr", {18'b0, mem_address}, 32'h42);
        step();
        step();
        issue(1'b0, 3'b101, 32'h0000_0107, 32'h0);
        step();
        step();
        chk("lhux_rdata", bus.resp_rdata, 32'h0000_ABCD);
        step();
        issue(1'b0, 3'b010, 32'h0000_FFFE, 32'h0);
        chk("wrap_acc0_addr", {18'b0, mem_address}, 32'h3FFF);
        step();
        chk("wrap_acc1_addr", {18'b0, mem_address}, 32'h0);
        step();
        chk("wrap_rdata", bus.resp_rdata, 32'hDDCC_BBAA);
        step();
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk("ill_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("ill_resp_error", {31'b0, bus.resp_error}, 32'd1);
        chk("ill_rdata", bus.resp_rdata, 32'd0);
        chk("ill_wren", {31'b0, mem_wren}, 32'd0);
        step();
        chk("ill_after_ready", {31'b0, bus.req_ready}, 32'd1);
        issue(1'b1, 3'b010, 32'h0000_01FE, 32'h1234_5678);
        chk("rsw_acc0_be", {28'b0, mem_byteena}, 32'hC);
        step();
        reset = 1'b1;
        #1;
        chk("rsw_acc1_wren", {31'b0, mem_wren}, 32'd0);
        step();
        chk("rsw_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rsw_ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        step();
        chk("rsw_ready_after", {31'b0, bus.req_ready}, 32'd1);
        chk("rsw_resp_after", {31'b0, bus.resp_valid}, 32'd0);
        chk("rsw_word0", mem[14'h007F], 32'h5678_0000);
        chk("rsw_word1", mem[14'h0080], 32'h4433_2211);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
